fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Drains bytes from a FIFO on the devboard (first-word-fall-through head, pop strobe, Empty flag) and serialises them as asynchronous UART frames on a single TX line.
- Consumer/read-side counterpart to the FIFO writer path. Host-side logic loads the FIFO; this block empties it onto the serial pin at a fixed baud rate.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per serial bit; legal range ≥2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- fifo_data  input  DATA_BITS  FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  pop strobe to the FIFO; exactly one clk wide per frame.
- tx_enable  input  1  permits new frames to start.
- txd  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, txd=1, fifo_rd=0, busy=0, counters=0, shift register=0. A reset mid-frame truncates the frame. txd returns high immediately. The byte already popped is lost; this is by design.
- States: IDLE, START, DATA, PARITY, STOP. busy = (state != IDLE). All outputs are registered.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and clears on each bit boundary. Every bit holds txd for exactly CLKS_PER_BIT clocks.
- Launch condition: a posedge in IDLE with tx_enable=1 and fifo_empty=0. At that edge:
  - shift register <= fifo_data;
  - state <= START, txd <= 0;
  - fifo_rd <= 1 for the following cycle only;
  - baud counter and bit index <= 0.
- Launch latency: txd falls 1 clk after the launch condition is sampled.
- fifo_data is sampled only at the launch edge. fifo_empty is ignored from launch until the last STOP cycle. The FIFO's flag/head update lag after a pop therefore never matters.
- START: txd=0 for one bit time, then DATA.
- DATA: LSB first; the bit index runs 0..DATA_BITS-1. After the last data bit, go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: txd = (XOR of the data bits) XOR PARITY_ODD, held for one bit time.
- STOP: txd=1 for STOP_BITS*CLKS_PER_BIT clocks.
- On the last STOP clock:
  - if tx_enable=1 and fifo_empty=0, apply the launch actions directly (zero idle gap, back-to-back frames);
  - otherwise go to IDLE.
- Frame length: exactly (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clocks.
- tx_enable deasserted mid-frame: the current frame completes unchanged, then the block stays in IDLE.
- fifo_rd is never asserted while fifo_empty=0 is unsampled, and never more than once per frame.
- FIFO going empty mid-frame has no effect.

Test Plan (CLKS_PER_BIT=4, 8N1 unless stated):
- Reset, fifo_empty=1, tx_enable=1 -> txd=1, busy=0, fifo_rd=0 for 100 clks.
- Single byte 0x55 -> exactly one fifo_rd pulse. txd 1 clk later reads 0,1,0,1,0,1,0,1,0,1, each held 4 clks (40 clks total). busy falls afterwards; txd stays high.
- FIFO holds 0xA3, 0x0F -> two frames with no idle gap: the second start bit begins the clk after 4 stop clocks. Exactly 2 fifo_rd pulses, 40 clks apart. The decoded bytes match, LSB first.
- PARITY_EN=1 with 0x07:
  - PARITY_ODD=0 -> parity bit 1;
  - PARITY_ODD=1 -> parity bit 0;
  - frame length 44 clks.
  - STOP_BITS=2 -> stop high 8 clks, frame 48 clks.
- tx_enable dropped in the DATA state with bytes pending -> the frame completes (40 clks), then no further fifo_rd or start bit until tx_enable returns high.
- reset asserted mid-DATA -> txd=1, busy=0, fifo_rd=0 in the same cycle (asynchronous). After release, the next queued byte is sent as a complete frame.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Pops words from a first-word-fall-through FIFO and sends each one as an
// asynchronous UART frame: start bit, DATA_BITS data bits LSB first, an
// optional parity bit, then STOP_BITS stop bits. Frames run back to back
// with no idle gap while tx_enable is high and the FIFO has data.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset       asynchronous, active-low reset
//   fifo_data   FIFO head word, valid whenever fifo_empty is low
//   fifo_empty  FIFO empty flag
//   fifo_rd     one-clock pop strobe, issued once per frame
//   tx_enable   permits new frames to start
//   txd         serial output, idles high
//   busy        high while a frame is in progress
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    input  logic                 tx_enable,
    output logic                 txd,
    output logic                 busy
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic              ODD_SEL   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic                   txd_q, txd_d;
    logic                   fifo_rd_q, fifo_rd_d;
    logic                   busy_q, busy_d;
    logic                   bit_end;
    logic                   launch;

    // Next-state logic. The shift register is consumed as data bits go out,
    // so the parity bit is computed once from the whole word at launch time.
    // bit_idx_q is reused to count stop bits when STOP_BITS is 2.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        fifo_rd_d = 1'b0;
        launch    = 1'b0;
        bit_end   = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (tx_enable && !fifo_empty) begin
                    launch = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                    txd_d     = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        // Last stop clock: chain straight into the next frame
                        // when possible, otherwise fall back to idle.
                        if (tx_enable && !fifo_empty) begin
                            launch = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            bit_idx_d = '0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                baud_d    = '0;
                bit_idx_d = '0;
                txd_d     = 1'b1;
            end
        endcase

        if (launch) begin
            state_d   = START;
            shift_d   = fifo_data;
            parity_d  = (^fifo_data) ^ ODD_SEL;
            txd_d     = 1'b0;
            fifo_rd_d = 1'b1;
            baud_d    = '0;
            bit_idx_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset truncates any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            fifo_rd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            fifo_rd_q <= fifo_rd_d;
            busy_q    <= busy_d;
        end
    end

    assign txd     = txd_q;
    assign fifo_rd = fifo_rd_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Three instances share clock, reset and tx_enable: 8N1, 8E1 and 8O2, all at
// four clocks per bit. Each has its own FIFO model fed with the same bytes.
// A reference model expands every launched byte into the expected per-clock
// txd waveform and predicts busy and fifo_rd each cycle.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CLKS = 4;
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic [7:0] fifo_data_w [NDUT];
    logic       fifo_empty_w[NDUT];
    logic       fifo_rd_w   [NDUT];
    logic       txd_w       [NDUT];
    logic       busy_w      [NDUT];

    logic [7:0] fifo_q[NDUT][$];
    bit         exp_q [NDUT][$];

    int   checks = 0;
    int   fails  = 0;
    int   cycle  = 0;
    int   rd_count = 0;
    int   last_rd_cycle = -1;
    int   rd_gap = 0;
    int   snap;
    int   busy_cycles[NDUT];
    int   frame_start[NDUT];
    logic par_sample [NDUT];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_w[0]), .fifo_empty(fifo_empty_w[0]),
        .fifo_rd(fifo_rd_w[0]), .tx_enable(tx_enable), .txd(txd_w[0]), .busy(busy_w[0]));

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_w[1]), .fifo_empty(fifo_empty_w[1]),
        .fifo_rd(fifo_rd_w[1]), .tx_enable(tx_enable), .txd(txd_w[1]), .busy(busy_w[1]));

    fifo_uart_tx #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd2 (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_w[2]), .fifo_empty(fifo_empty_w[2]),
        .fifo_rd(fifo_rd_w[2]), .tx_enable(tx_enable), .txd(txd_w[2]), .busy(busy_w[2]));

    function automatic int pe_of(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic bit po_of(input int i);
        return (i == 2);
    endfunction

    function automatic int sb_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // Expand one byte into the per-clock txd values of its whole frame.
    function automatic void add_frame(input int i, input logic [7:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (pe_of(i) != 0) bits.push_back((^d) ^ po_of(i));
        for (int s = 0; s < sb_of(i); s++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CLKS; c++) exp_q[i].push_back(bits[k]);
        end
    endfunction

    // Present FIFO heads; an empty FIFO shows garbage on its data lines.
    task automatic refresh_fifo_inputs();
        for (int i = 0; i < NDUT; i++) begin
            if (fifo_q[i].size() > 0) begin
                fifo_empty_w[i] = 1'b0;
                fifo_data_w[i]  = fifo_q[i][0];
            end else begin
                fifo_empty_w[i] = 1'b1;
                fifo_data_w[i]  = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 0; i < NDUT; i++) fifo_q[i].push_back(b);
        refresh_fifo_inputs();
    endtask

    task automatic checkOutput(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s dut=%0d cycle=%0d observed=%0h expected=%0h", tag, idx, cycle, obs, exp);
        end
    endtask

    // One clock: sample inputs before the edge, advance the model at the
    // edge, compare 1 time unit later, then let each FIFO honour its pop.
    task automatic step();
        logic       en_s;
        logic       rst_s;
        logic       emp_s [NDUT];
        logic [7:0] dat_s [NDUT];
        logic       txd_e [NDUT];
        logic       busy_e[NDUT];
        logic       rd_e  [NDUT];
        en_s  = tx_enable;
        rst_s = reset;
        for (int i = 0; i < NDUT; i++) begin
            emp_s[i] = fifo_empty_w[i];
            dat_s[i] = fifo_data_w[i];
        end
        @(posedge clk);
        cycle++;
        for (int i = 0; i < NDUT; i++) begin
            rd_e[i] = 1'b0;
            if (!rst_s) begin
                exp_q[i].delete();
                txd_e[i]  = 1'b1;
                busy_e[i] = 1'b0;
            end else begin
                if (exp_q[i].size() == 0 && en_s && !emp_s[i]) begin
                    add_frame(i, dat_s[i]);
                    rd_e[i] = 1'b1;
                end
                if (exp_q[i].size() > 0) begin
                    txd_e[i]  = exp_q[i].pop_front();
                    busy_e[i] = 1'b1;
                end else begin
                    txd_e[i]  = 1'b1;
                    busy_e[i] = 1'b0;
                end
            end
        end
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput("txd", i, 32'(txd_w[i]), 32'(txd_e[i]));
            checkOutput("busy", i, 32'(busy_w[i]), 32'(busy_e[i]));
            checkOutput("fifo_rd", i, 32'(fifo_rd_w[i]), 32'(rd_e[i]));
            if (busy_w[i] === 1'b1) busy_cycles[i]++;
            if (fifo_rd_w[i] === 1'b1) begin
                frame_start[i] = cycle;
                if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
            end
            if (cycle - frame_start[i] == 37) par_sample[i] = txd_w[i];
        end
        if (fifo_rd_w[0] === 1'b1) begin
            rd_count++;
            if (last_rd_cycle >= 0) rd_gap = cycle - last_rd_cycle;
            last_rd_cycle = cycle;
        end
        refresh_fifo_inputs();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NDUT; i++) begin
            busy_cycles[i] = 0;
            par_sample[i]  = 1'bx;
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) frame_start[i] = -1000;
        clear_stats();
        reset     = 1'b0;
        tx_enable = 1'b1;
        refresh_fifo_inputs();

        // Reset held, then 100 idle clocks with an empty FIFO.
        repeat (3) step();
        reset = 1'b1;
        repeat (100) step();

        // Single byte 0x55.
        clear_stats();
        snap = rd_count;
        applyStimulus(8'h55);
        repeat (60) step();
        checkOutput("rd_pulses_55", 0, 32'(rd_count - snap), 32'd1);
        checkOutput("frame_len_8n1", 0, 32'(busy_cycles[0]), 32'd40);
        checkOutput("frame_len_8e1", 1, 32'(busy_cycles[1]), 32'd44);
        checkOutput("frame_len_8o2", 2, 32'(busy_cycles[2]), 32'd48);

        // Back-to-back frames 0xA3, 0x0F.
        clear_stats();
        snap = rd_count;
        applyStimulus(8'hA3);
        applyStimulus(8'h0F);
        repeat (120) step();
        checkOutput("rd_pulses_b2b", 0, 32'(rd_count - snap), 32'd2);
        checkOutput("rd_gap_b2b", 0, 32'(rd_gap), 32'd40);
        checkOutput("busy_b2b", 0, 32'(busy_cycles[0]), 32'd80);

        // Parity of 0x07: even parity 1, odd parity 0.
        clear_stats();
        applyStimulus(8'h07);
        repeat (60) step();
        checkOutput("parity_even", 1, 32'(par_sample[1]), 32'd1);
        checkOutput("parity_odd", 2, 32'(par_sample[2]), 32'd0);
        checkOutput("frame_len_8e1_07", 1, 32'(busy_cycles[1]), 32'd44);
        checkOutput("frame_len_8o2_07", 2, 32'(busy_cycles[2]), 32'd48);

        // tx_enable dropped mid-DATA with bytes pending.
        snap = rd_count;
        repeat (3) applyStimulus(8'($urandom_range(0, 255)));
        repeat (15) step();
        tx_enable = 1'b0;
        repeat (80) step();
        checkOutput("rd_pulses_en_off", 0, 32'(rd_count - snap), 32'd1);
        checkOutput("busy_en_off", 0, 32'(busy_w[0]), 32'd0);
        tx_enable = 1'b1;
        repeat (200) step();
        for (int i = 0; i < NDUT; i++)
            checkOutput("drained_en_on", i, 32'(fifo_q[i].size()), 32'd0);

        // Asynchronous reset mid-DATA; the next queued byte goes out whole.
        snap = rd_count;
        repeat (2) applyStimulus(8'($urandom_range(0, 255)));
        repeat (15) step();
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput("txd_async_rst", i, 32'(txd_w[i]), 32'd1);
            checkOutput("busy_async_rst", i, 32'(busy_w[i]), 32'd0);
            checkOutput("rd_async_rst", i, 32'(fifo_rd_w[i]), 32'd0);
            exp_q[i].delete();
        end
        repeat (3) step();
        reset = 1'b1;
        repeat (100) step();
        checkOutput("rd_pulses_rst", 0, 32'(rd_count - snap), 32'd2);
        for (int i = 0; i < NDUT; i++)
            checkOutput("drained_rst", i, 32'(fifo_q[i].size()), 32'd0);

        // Random bytes with tx_enable toggling at random.
        repeat (8) applyStimulus(8'($urandom_range(0, 255)));
        repeat (500) begin
            if ($urandom_range(0, 24) == 0) tx_enable = ~tx_enable;
            step();
        end
        tx_enable = 1'b1;
        repeat (450) step();
        for (int i = 0; i < NDUT; i++)
            checkOutput("drained_random", i, 32'(fifo_q[i].size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
